mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port, fixed-latency unified memory between instruction fetch (IF) and the
//  load/store path driven by control_unit's mem_read/mem_write. Arbitrates, issues one
//  transaction at a time, and returns read data/completion to the owning requester.
//  Sits between the core datapath and the memory macro; the core stalls on gnt/rvalid.
// PARAMETERS
//  ADDR_W           32  address width
//  DATA_W           32  data width
//  MEM_LAT          2   cycles from mem_en to valid mem_rdata (>=1)
//  MAX_DATA_STREAK  4   consecutive data grants allowed while IF waits (>=1)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  if_req     in   1       fetch request; held with if_addr until if_gnt
//  if_addr    in   ADDR_W  fetch address
//  if_gnt     out  1       fetch accepted this cycle
//  if_rvalid  out  1       1-cycle pulse: if_rdata valid
//  if_rdata   out  DATA_W  fetched word
//  d_req      in   1       data request (mem_read|mem_write); held until d_gnt
//  d_we       in   1       1=store, 0=load
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_gnt      out  1       data request accepted this cycle
//  d_rvalid   out  1       1-cycle pulse: load data valid / store complete
//  d_rdata    out  DATA_W  load data
//  mem_en     out  1       memory access strobe (1 cycle per transaction)
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  - Reset: state IDLE, latency counter 0, streak 0, owner IF; all gnt/rvalid/mem_en/mem_we 0,
//    rdata registers 0. Reset mid-transaction drops it: no rvalid ever issued for it.
//  - FSM IDLE -> WAIT -> IDLE. Grant only in IDLE (incl. the cycle rvalid is high).
//  - IDLE: if any req, pick winner combinationally; assert winner gnt and mem_en in the same
//    cycle (cycle g). mem_addr/mem_we/mem_wdata muxed from winner; mem_we = d_we for data,
//    0 for IF; mem_wdata = 0 when not a store. Latch owner/we, load counter = MEM_LAT-1, go WAIT.
//  - Priority: data beats IF, except when if_req=1 and streak==MAX_DATA_STREAK -> IF wins.
//    streak: +1 on data grant while if_req=1; cleared on IF grant or data grant with if_req=0;
//    saturates at MAX_DATA_STREAK.
//  - WAIT: counter decrements each cycle; when 0, sample mem_rdata at end of cycle g+MEM_LAT
//    into owner's rdata register, pulse owner's rvalid in cycle g+MEM_LAT+1, return to IDLE.
//    Throughput: one transaction per MEM_LAT+1 cycles.
//  - Stores: d_rvalid pulses as completion ack; d_rdata keeps its previous value.
//  - Non-owner rdata holds; non-owner rvalid stays 0. At most one of if_gnt/d_gnt per cycle.
//  - Requests arriving or deasserting in WAIT are ignored; no gnt until IDLE.
//  - Requester dropping req before gnt: legal, nothing issued.
//  - mem_en=0 -> mem_we=0, mem_addr/mem_wdata driven 0.
// STRUCTURE
//  - Shared package mem_arb_pkg: state enum (IDLE, WAIT), owner enum (OWN_IF, OWN_D).
//  - One sub-module: mem_arb_select (combinational winner pick from if_req, d_req, streak).
//  - Counter width $clog2(MEM_LAT+1); streak width $clog2(MAX_DATA_STREAK+1).
// TESTING (MEM_LAT=2, MAX_DATA_STREAK=4)
//  1. if_req, if_addr=0x100, mem returns 0xDEADBEEF -> if_gnt/mem_en cycle 0, if_rvalid with
//     if_rdata=0xDEADBEEF in cycle 3, single pulse.
//  2. if_req and d_req (load 0x40) same cycle -> d_gnt cycle 0, if_gnt cycle 3, d_rvalid 3,
//     if_rvalid 6.
//  3. d_req and if_req held continuously -> grant order D,D,D,D,I,D,D,D,D,I.
//  4. store d_addr=0x40 d_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234 in cycle 0; d_rvalid cycle
//     3; d_rdata unchanged.
//  5. rst pulsed in cycle 1 of a fetch -> no if_rvalid; if_gnt 1 cycle after rst release.
//  6. no requests for 20 cycles -> mem_en, gnt, rvalid all 0 throughout.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state and transaction owner.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side (fetch, load/store) and memory-macro-side signals of the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_select.sv
// Combinational winner pick: data has priority unless fetch has waited out a full data streak.
module mem_arb_select #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int STREAK_W        = 3
) (
  input  logic                i_if_req,
  input  logic                i_d_req,
  input  logic [STREAK_W-1:0] i_streak,
  output logic                o_if_win,
  output logic                o_d_win
);

  logic w_if_starved;

  assign w_if_starved = i_if_req && (i_streak == STREAK_W'(MAX_DATA_STREAK));
  assign o_d_win      = i_d_req && !w_if_starved;
  assign o_if_win     = i_if_req && !o_d_win;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and the load/store path,
// one transaction in flight at a time, read data routed back to the owning requester.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MEM_LAT         = 2,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int CNT_W    = $clog2(MEM_LAT + 1);
  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  state_e              r_state;
  owner_e              r_owner;
  logic                r_we;
  logic [CNT_W-1:0]    r_cnt;
  logic [STREAK_W-1:0] r_streak;
  logic                r_if_rvalid;
  logic                r_d_rvalid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  logic w_idle;
  logic w_if_win;
  logic w_d_win;
  logic w_if_gnt;
  logic w_d_gnt;
  logic w_store;

  mem_arb_select #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK),
    .STREAK_W        (STREAK_W)
  ) u_select (
    .i_if_req (bus.if_req),
    .i_d_req  (bus.d_req),
    .i_streak (r_streak),
    .o_if_win (w_if_win),
    .o_d_win  (w_d_win)
  );

  // Grants are combinational from IDLE; holding them low while rst is high keeps the bus quiet.
  assign w_idle   = (r_state == IDLE) && !rst;
  assign w_if_gnt = w_idle && w_if_win;
  assign w_d_gnt  = w_idle && w_d_win;
  assign w_store  = w_d_gnt && bus.d_we;

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.mem_en    = w_if_gnt || w_d_gnt;
  assign bus.mem_we    = w_store;
  assign bus.mem_addr  = w_d_gnt  ? bus.d_addr  :
                         w_if_gnt ? bus.if_addr : '0;
  assign bus.mem_wdata = w_store  ? bus.d_wdata : '0;

  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rvalid  = r_d_rvalid;
  assign bus.d_rdata   = r_d_rdata;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
  // the rdata registers are plain flops (not a memory array), so resetting them is cheap and defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_streak    <= '0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      if (r_state == IDLE) begin
        if (w_if_gnt || w_d_gnt) begin
          r_state <= WAIT;
          r_owner <= w_d_gnt ? OWN_D : OWN_IF;
          r_we    <= w_store;
          r_cnt   <= CNT_W'(MEM_LAT - 1);
          if (w_d_gnt && bus.if_req) begin
            if (r_streak != STREAK_W'(MAX_DATA_STREAK))
              r_streak <= r_streak + 1'b1;
          end else begin
            r_streak <= '0;
          end
        end
      end else if (r_cnt == '0) begin
        r_state <= IDLE;
        if (r_owner == OWN_IF) begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= bus.mem_rdata;
        end else begin
          r_d_rvalid <= 1'b1;
          if (!r_we)
            r_d_rdata <= bus.mem_rdata;
        end
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (MEM_LAT=2, MAX_DATA_STREAK=4): directed stimulus pushes
// expected grants/responses, a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    bit          is_d;
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rv_t;

  gnt_t gnt_q[$];
  rv_t  if_q[$];
  rv_t  d_q[$];
  gnt_t ge;
  rv_t  re;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

  mem_port_arbiter #(
    .ADDR_W          (32),
    .DATA_W          (32),
    .MEM_LAT         (2),
    .MAX_DATA_STREAK (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory macro model: word array, read data appears two cycles after the strobe.
  logic [31:0] mem_m [0:1023];
  logic [31:0] p1;
  logic [31:0] p2;

  always @(posedge clk) begin
    if (ifc.mem_en && ifc.mem_we)
      mem_m[ifc.mem_addr[11:2]] <= ifc.mem_wdata;
    p1 <= ifc.mem_en ? mem_m[ifc.mem_addr[11:2]] : 32'h0;
    p2 <= p1;
  end
  assign ifc.mem_rdata = p2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    check("gnt_onehot", {63'd0, ifc.if_gnt && ifc.d_gnt}, 64'd0);
    check("mem_en_vs_gnt", {63'd0, ifc.mem_en}, {63'd0, ifc.if_gnt || ifc.d_gnt});
    if (!ifc.mem_en)
      check("idle_bus", {ifc.mem_we, ifc.mem_addr[30:0], ifc.mem_wdata}, 64'd0);
    if (ifc.if_gnt || ifc.d_gnt) begin
      if (gnt_q.size() == 0) begin
        check("unexpected_gnt", 64'd1, 64'd0);
      end else begin
        ge = gnt_q.pop_front();
        check("gnt_port", {63'd0, ifc.d_gnt}, {63'd0, ge.is_d});
        check("gnt_cycle", 64'(cyc), 64'(ge.cyc));
        check("mem_addr", {32'd0, ifc.mem_addr}, {32'd0, ge.addr});
        check("mem_we", {63'd0, ifc.mem_we}, {63'd0, ge.we});
        check("mem_wdata", {32'd0, ifc.mem_wdata}, {32'd0, ge.wdata});
      end
    end
    if (ifc.if_rvalid) begin
      if (if_q.size() == 0) begin
        check("unexpected_if_rvalid", 64'd1, 64'd0);
      end else begin
        re = if_q.pop_front();
        check("if_rvalid_cycle", 64'(cyc), 64'(re.cyc));
        check("if_rdata", {32'd0, ifc.if_rdata}, {32'd0, re.data});
      end
    end
    if (ifc.d_rvalid) begin
      if (d_q.size() == 0) begin
        check("unexpected_d_rvalid", 64'd1, 64'd0);
      end else begin
        re = d_q.pop_front();
        check("d_rvalid_cycle", 64'(cyc), 64'(re.cyc));
        check("d_rdata", {32'd0, ifc.d_rdata}, {32'd0, re.data});
      end
    end
  end

  task automatic push_gnt(input bit is_d, input int c, input logic [31:0] addr,
                          input logic we, input logic [31:0] wdata);
    gnt_t g;
    g.is_d = is_d; g.cyc = c; g.addr = addr; g.we = we; g.wdata = wdata;
    gnt_q.push_back(g);
  endtask

  task automatic push_if(input int c, input logic [31:0] data);
    rv_t r;
    r.cyc = c; r.data = data;
    if_q.push_back(r);
  endtask

  task automatic push_d(input int c, input logic [31:0] data);
    rv_t r;
    r.cyc = c; r.data = data;
    d_q.push_back(r);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic if_fetch(input logic [31:0] addr);
    bit got;
    got = 1'b0;
    ifc.if_req  = 1'b1;
    ifc.if_addr = addr;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = ifc.if_gnt;
    end
    if (!got) check("if_gnt_timeout", 64'd0, 64'd1);
    step(1);
    ifc.if_req  = 1'b0;
    ifc.if_addr = '0;
  endtask

  task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bit got;
    got = 1'b0;
    ifc.d_req   = 1'b1;
    ifc.d_we    = we;
    ifc.d_addr  = addr;
    ifc.d_wdata = wdata;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = ifc.d_gnt;
    end
    if (!got) check("d_gnt_timeout", 64'd0, 64'd1);
    step(1);
    ifc.d_req   = 1'b0;
    ifc.d_we    = 1'b0;
    ifc.d_addr  = '0;
    ifc.d_wdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    checks = 0;
    errors = 0;
    cyc    = 0;
    for (int i = 0; i < 1024; i++) mem_m[i] = 32'h0;
    mem_m[32'h100 >> 2] = 32'hDEADBEEF;
    mem_m[32'h040 >> 2] = 32'hCAFE0040;
    mem_m[32'h200 >> 2] = 32'h0BADF00D;
    mem_m[32'h080 >> 2] = 32'h80808080;
    mem_m[32'h300 >> 2] = 32'h30303030;
    rst = 1'b1;
    ifc.if_req = 1'b0; ifc.if_addr = '0;
    ifc.d_req = 1'b0; ifc.d_we = 1'b0; ifc.d_addr = '0; ifc.d_wdata = '0;

    // Reset state: everything quiet and zero.
    step(2);
    @(negedge clk);
    check("rst_outputs", {58'd0, ifc.if_gnt, ifc.d_gnt, ifc.if_rvalid, ifc.d_rvalid,
                          ifc.mem_en, ifc.mem_we}, 64'd0);
    check("rst_rdata", {ifc.if_rdata, ifc.d_rdata}, 64'd0);
    step(1);
    rst = 1'b0;
    step(2);

    // 1: single fetch, response three cycles after grant.
    t0 = cyc;
    push_gnt(1'b0, t0, 32'h100, 1'b0, 32'h0);
    push_if(t0 + 3, 32'hDEADBEEF);
    if_fetch(32'h100);
    step(5);

    // 2: simultaneous fetch and load; data wins first.
    t0 = cyc;
    push_gnt(1'b1, t0,     32'h040, 1'b0, 32'h0);
    push_gnt(1'b0, t0 + 3, 32'h200, 1'b0, 32'h0);
    push_d(t0 + 3, 32'hCAFE0040);
    push_if(t0 + 6, 32'h0BADF00D);
    fork
      if_fetch(32'h200);
      d_access(1'b0, 32'h040, 32'h0);
    join
    step(4);

    // 3: both held; fetch gets in after four data grants.
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) begin
        push_gnt(1'b0, t0 + 3 * k, 32'h300, 1'b0, 32'h0);
        push_if(t0 + 3 * k + 3, 32'h30303030);
      end else begin
        push_gnt(1'b1, t0 + 3 * k, 32'h080, 1'b0, 32'h0);
        push_d(t0 + 3 * k + 3, 32'h80808080);
      end
    end
    ifc.if_req = 1'b1; ifc.if_addr = 32'h300;
    ifc.d_req = 1'b1; ifc.d_we = 1'b0; ifc.d_addr = 32'h080;
    step(28);
    ifc.if_req = 1'b0; ifc.if_addr = '0;
    ifc.d_req = 1'b0; ifc.d_addr = '0;
    step(4);

    // 4: store acks without touching d_rdata, then a load sees the stored word.
    t0 = cyc;
    push_gnt(1'b1, t0, 32'h040, 1'b1, 32'h1234);
    push_d(t0 + 3, 32'h80808080);
    d_access(1'b1, 32'h040, 32'h1234);
    step(3);
    t0 = cyc;
    push_gnt(1'b1, t0, 32'h040, 1'b0, 32'h0);
    push_d(t0 + 3, 32'h00001234);
    d_access(1'b0, 32'h040, 32'h0);
    step(4);

    // 5: reset during the cycle after a fetch grant; the dropped fetch never responds.
    t0 = cyc;
    push_gnt(1'b0, t0,     32'h100, 1'b0, 32'h0);
    push_gnt(1'b0, t0 + 2, 32'h100, 1'b0, 32'h0);
    push_if(t0 + 5, 32'hDEADBEEF);
    if_fetch(32'h100);
    rst = 1'b1;
    ifc.if_req = 1'b1; ifc.if_addr = 32'h100;
    @(negedge clk);
    check("midrst_rdata", {ifc.if_rdata, ifc.d_rdata}, 64'd0);
    check("midrst_gnt", {62'd0, ifc.if_gnt, ifc.mem_en}, 64'd0);
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_if_gnt", {63'd0, ifc.if_gnt}, 64'd1);
    step(1);
    ifc.if_req = 1'b0; ifc.if_addr = '0;
    step(5);

    // 6: no requests, bus stays idle.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("idle_quiet", {59'd0, ifc.mem_en, ifc.if_gnt, ifc.d_gnt, ifc.if_rvalid,
                           ifc.d_rvalid}, 64'd0);
    end

    check("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
    check("if_q_drained", 64'(if_q.size()), 64'd0);
    check("d_q_drained", 64'(d_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
